// File: rtl/rom_cache_segment.sv
// rom_cache_segment: per-ROM client front end in front of the SDRAM ROM arbiter.
// It serves ROM reads from a small direct-mapped cache. Each line holds one
// 32-bit SDRAM word. A miss issues a single fill request to the arbiter.
// When the fill data arrives it is written into the line and bypassed to
// rom_data in the same cycle.
// Optional feature macro: ROM_SEGMENT_STATS_EN. It adds the hit_count and
// miss_count saturating counters.
module rom_cache_segment #(
    parameter int          ROM_ADDR_WIDTH = 17,
    parameter int          ROM_DATA_WIDTH = 16,
    parameter logic [23:0] ROM_OFFSET     = 24'h0,
    parameter int          LINES          = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cs,
    input  logic                      oe,
    input  logic [22:0]               rom_addr,
    output logic [ROM_DATA_WIDTH-1:0] rom_data,
    input  logic                      flush,
    output logic [22:0]               ctrl_addr,
    output logic                      ctrl_req,
    input  logic                      ctrl_ack,
    input  logic                      ctrl_valid,
    output logic                      ctrl_hit,
    input  logic [31:0]               ctrl_data
`ifdef ROM_SEGMENT_STATS_EN
    ,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count
`endif
);

    localparam int DW  = ROM_DATA_WIDTH;
    localparam int BPW = DW / 8;          // bytes per ROM word
    localparam int BSH = $clog2(BPW);     // ROM word -> byte shift
    localparam int IW  = $clog2(LINES);   // line index width
    localparam int TW  = 23 - IW;         // tag width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Pick the DW-bit little-endian lane out of a 32-bit SDRAM word.
    function automatic logic [DW-1:0] lane_sel(input logic [31:0] w, input logic [1:0] lane);
        logic [31:0] sh;
        sh = w >> (32'(lane) * 32'(DW));
        return sh[DW-1:0];
    endfunction

    // Address decode
    logic [23:0]   byte_s;
    logic [23:0]   sum_s;
    logic [22:0]   sword_s;
    logic [1:0]    lane_s;
    logic [IW-1:0] idx_s;
    logic [TW-1:0] tag_s;
    logic          unused_s;

    assign byte_s  = 24'(rom_addr[ROM_ADDR_WIDTH-1:0]) << BSH;
    assign sum_s   = ROM_OFFSET + byte_s;              // carry out dropped
    assign sword_s = {1'b0, sum_s[23:2]};
    assign lane_s  = byte_s[1:0] >> BSH;
    assign idx_s   = sword_s[IW-1:0];
    assign tag_s   = sword_s[22:IW];

    generate
        if (ROM_ADDR_WIDTH < 23) begin : g_unused_hi
            assign unused_s = ^{rom_addr[22:ROM_ADDR_WIDTH], sum_s[1:0]};
        end else begin : g_unused_lo
            assign unused_s = ^sum_s[1:0];
        end
    endgenerate

    // Line storage and control state
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    state_t        state_q, state_d;
    logic [22:0]   addr_q, addr_d;     // latched SDRAM word of the pending fill
    logic          stale_q, stale_d;   // pending fill invalidated by a flush
    logic          fill_s;             // fill data arrives this cycle
    logic          wr_s;               // fill data is written into the line
    logic          bypass_s;
    logic [IW-1:0] fill_idx_s;
    logic [TW-1:0] fill_tag_s;

    assign fill_idx_s = addr_q[IW-1:0];
    assign fill_tag_s = addr_q[22:IW];
    assign ctrl_addr  = addr_q;

    // Hit lookup against the addressed line
    always_comb begin
        ctrl_hit = cs & oe & valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    end

    // Fill qualification: an ack together with valid in REQ counts as an immediate fill
    always_comb begin
        fill_s   = ((state_q == S_REQ) & ctrl_ack & ctrl_valid) | ((state_q == S_WAIT) & ctrl_valid);
        wr_s     = fill_s & ~stale_q & ~flush;
        bypass_s = fill_s & (sword_s == addr_q);
    end

    // Read data: fill data is forwarded in its own cycle, otherwise the line is used
    always_comb begin
        if (bypass_s) begin
            rom_data = lane_sel(ctrl_data, lane_s);
        end else begin
            rom_data = lane_sel(data_q[idx_s], lane_s);
        end
    end

    // FSM state register plus the latched request address and stale flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 23'd0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stale_q <= stale_d;
        end
    end

    // FSM next state: a miss is launched only from IDLE, and the request is held until ack
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (cs & oe & ~ctrl_hit & ~flush) begin
                    state_d = S_REQ;
                    addr_d  = sword_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ctrl_ack) begin
                    if (ctrl_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (ctrl_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stale tracking: a flush during an outstanding fill discards that fill, and the flag clears when the fill retires
    always_comb begin
        stale_d = stale_q;
        if (state_q == S_IDLE) begin
            stale_d = 1'b0;
        end else if (fill_s) begin
            stale_d = 1'b0;
        end else if (flush) begin
            stale_d = 1'b1;
        end else begin
            stale_d = stale_q;
        end
    end

    // FSM outputs
    always_comb begin
        case (state_q)
            S_REQ:   ctrl_req = 1'b1;
            default: ctrl_req = 1'b0;
        endcase
    end

    // Line storage: flush clears all valid bits and wins over a coincident fill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 32'd0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_s) begin
            valid_q[fill_idx_s] <= 1'b1;
            tag_q[fill_idx_s]   <= fill_tag_s;
            data_q[fill_idx_s]  <= ctrl_data;
        end
    end

`ifdef ROM_SEGMENT_STATS_EN
    // Saturating increment for the statistics counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic [22:0] prev_sword_q;
    logic        prev_csoe_q;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        hit_ev_s;
    logic        miss_ev_s;

    // Count a hit only once per new access: a new address, or cs&oe just rising
    always_comb begin
        hit_ev_s  = ctrl_hit & ((sword_s != prev_sword_q) | ~prev_csoe_q);
        miss_ev_s = (state_q == S_IDLE) & (state_d == S_REQ);
    end

    // Statistics counters, cleared by flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sword_q <= 23'd0;
            prev_csoe_q  <= 1'b0;
            hit_cnt_q    <= 16'd0;
            miss_cnt_q   <= 16'd0;
        end else begin
            prev_sword_q <= sword_s;
            prev_csoe_q  <= cs & oe;
            if (flush) begin
                hit_cnt_q  <= 16'd0;
                miss_cnt_q <= 16'd0;
            end else begin
                if (hit_ev_s) begin
                    hit_cnt_q <= sat_inc(hit_cnt_q);
                end
                if (miss_ev_s) begin
                    miss_cnt_q <= sat_inc(miss_cnt_q);
                end
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_rom_cache_segment.sv
// Bench for rom_cache_segment. Three instances share the bus inputs but have
// their own cs: A (DW16 @ 0x040000), B (DW8 @ 0x0A0000) and C (DW32 @ 0).
// Read data expectations go through a scoreboard queue.
module tb_rom_cache_segment;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        oe = 1'b0, flush = 1'b0, ack = 1'b0, valid = 1'b0;
    logic        cs_a = 1'b0, cs_b = 1'b0, cs_c = 1'b0;
    logic [22:0] rom_addr = 23'd0;
    logic [31:0] cdata = 32'd0;

    logic [15:0] rd_a;
    logic [7:0]  rd_b;
    logic [31:0] rd_c;
    logic [22:0] caddr_a, caddr_b, caddr_c;
    logic        req_a, req_b, req_c, hit_a, hit_b, hit_c;
`ifdef ROM_SEGMENT_STATS_EN
    logic [15:0] hc_a, mc_a, hc_b, mc_b, hc_c, mc_c;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    rom_cache_segment #(.ROM_ADDR_WIDTH(17), .ROM_DATA_WIDTH(16), .ROM_OFFSET(24'h040000), .LINES(16)) u_a (
        .clk(clk), .reset(reset), .cs(cs_a), .oe(oe), .rom_addr(rom_addr), .rom_data(rd_a),
        .flush(flush), .ctrl_addr(caddr_a), .ctrl_req(req_a), .ctrl_ack(ack), .ctrl_valid(valid),
        .ctrl_hit(hit_a), .ctrl_data(cdata)
`ifdef ROM_SEGMENT_STATS_EN
        , .hit_count(hc_a), .miss_count(mc_a)
`endif
    );

    rom_cache_segment #(.ROM_ADDR_WIDTH(17), .ROM_DATA_WIDTH(8), .ROM_OFFSET(24'h0A0000), .LINES(16)) u_b (
        .clk(clk), .reset(reset), .cs(cs_b), .oe(oe), .rom_addr(rom_addr), .rom_data(rd_b),
        .flush(flush), .ctrl_addr(caddr_b), .ctrl_req(req_b), .ctrl_ack(ack), .ctrl_valid(valid),
        .ctrl_hit(hit_b), .ctrl_data(cdata)
`ifdef ROM_SEGMENT_STATS_EN
        , .hit_count(hc_b), .miss_count(mc_b)
`endif
    );

    rom_cache_segment #(.ROM_ADDR_WIDTH(17), .ROM_DATA_WIDTH(32), .ROM_OFFSET(24'h000000), .LINES(16)) u_c (
        .clk(clk), .reset(reset), .cs(cs_c), .oe(oe), .rom_addr(rom_addr), .rom_data(rd_c),
        .flush(flush), .ctrl_addr(caddr_c), .ctrl_req(req_c), .ctrl_ack(ack), .ctrl_valid(valid),
        .ctrl_hit(hit_c), .ctrl_data(cdata)
`ifdef ROM_SEGMENT_STATS_EN
        , .hit_count(hc_c), .miss_count(mc_c)
`endif
    );

    // Comparison with counting and reporting
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop_chk(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    // Reference read-data model: little-endian lane of a word, derived from the ROM byte address
    function automatic logic [31:0] model_rd(input logic [31:0] w, input int dw, input logic [22:0] a);
        int bpw;
        int b;
        int lane;
        logic [31:0] r;
        bpw  = dw / 8;
        b    = int'(a) * bpw;
        lane = (b % 4) / bpw;
        r    = w >> (lane * dw);
        if (dw < 32) r = r & ((32'h1 << dw) - 32'h1);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, req_a}, 32'd0);
        chk("rst_caddr", {9'd0, caddr_a}, 32'd0);
        chk("rst_rdata", {16'd0, rd_a}, 32'd0);
`ifdef ROM_SEGMENT_STATS_EN
        chk("rst_hitcnt", {16'd0, hc_a}, 32'd0);
        chk("rst_misscnt", {16'd0, mc_a}, 32'd0);
`endif
        reset = 1'b0;

        // Test 1: miss on rom_addr 5, request held until ack, then fill with bypass
        cyc(); cs_a = 1'b1; oe = 1'b1; rom_addr = 23'd5; #1;
        chk("t1_miss_hit", {31'd0, hit_a}, 32'd0);
        chk("t1_req_idle", {31'd0, req_a}, 32'd0);
        cyc(); #1;
        chk("t1_req", {31'd0, req_a}, 32'd1);
        chk("t1_caddr", {9'd0, caddr_a}, 32'h010002);
        cyc(); ack = 1'b1; #1;
        chk("t1_req_hold", {31'd0, req_a}, 32'd1);
        chk("t1_caddr_hold", {9'd0, caddr_a}, 32'h010002);
        cyc(); ack = 1'b0; valid = 1'b1; cdata = 32'hDEADBEEF; sb_push("t1_bypass", 32'h0000DEAD); #1;
        chk("t1_req_wait", {31'd0, req_a}, 32'd0);
        sb_pop_chk({16'd0, rd_a});
        cyc(); valid = 1'b0; cdata = 32'd0; sb_push("t1_line", 32'h0000DEAD); #1;
        chk("t1_hit_after", {31'd0, hit_a}, 32'd1);
        sb_pop_chk({16'd0, rd_a});

        // Test 2: other half of the same word hits immediately
        cyc(); cs_a = 1'b0; #1;
        cyc(); cs_a = 1'b1; rom_addr = 23'd4; sb_push("t2_rdata", 32'h0000BEEF); #1;
        chk("t2_hit", {31'd0, hit_a}, 32'd1);
        sb_pop_chk({16'd0, rd_a});
        chk("t2_noreq0", {31'd0, req_a}, 32'd0);
        cyc(); #1;
        chk("t2_noreq1", {31'd0, req_a}, 32'd0);
`ifdef ROM_SEGMENT_STATS_EN
        chk("t2_misscnt", {16'd0, mc_a}, 32'd1);
        chk("t2_hitcnt", {16'd0, hc_a}, 32'd1);
`endif

        // Test 3: byte-wide ROM
        cyc(); cs_a = 1'b0; cs_b = 1'b1; rom_addr = 23'd3; #1;
        chk("t3_miss_hit", {31'd0, hit_b}, 32'd0);
        cyc(); #1;
        chk("t3_req", {31'd0, req_b}, 32'd1);
        chk("t3_caddr", {9'd0, caddr_b}, 32'h028000);
        cyc(); ack = 1'b1; #1;
        cyc(); ack = 1'b0; valid = 1'b1; cdata = 32'h11223344; sb_push("t3_bypass", 32'h11); #1;
        sb_pop_chk({24'd0, rd_b});
        cyc(); valid = 1'b0; #1;
        chk("t3_hit_after", {31'd0, hit_b}, 32'd1);
        cyc(); rom_addr = 23'd0; sb_push("t3_lane0", model_rd(32'h11223344, 8, 23'd0)); #1;
        chk("t3_hit_lane0", {31'd0, hit_b}, 32'd1);
        sb_pop_chk({24'd0, rd_b});

        // Flush while the request is outstanding: the later fill is stale and not written
        cyc(); rom_addr = 23'd100; #1;
        chk("st_miss", {31'd0, hit_b}, 32'd0);
        cyc(); flush = 1'b1; #1;
        chk("st_req", {31'd0, req_b}, 32'd1);
        cyc(); flush = 1'b0; ack = 1'b1; #1;
        chk("st_req_kept", {31'd0, req_b}, 32'd1);
        cyc(); ack = 1'b0; cs_b = 1'b0; #1;
        chk("st_wait", {31'd0, req_b}, 32'd0);
        cyc(); valid = 1'b1; cdata = 32'h55667788; #1;
        cyc(); valid = 1'b0; cs_b = 1'b1; #1;
        chk("st_not_written", {31'd0, hit_b}, 32'd0);
        cyc(); #1;
        chk("st_rereq", {31'd0, req_b}, 32'd1);
        cyc(); ack = 1'b1; valid = 1'b1; cdata = 32'h99AABBCC; #1;
        cyc(); ack = 1'b0; valid = 1'b0; sb_push("st_refill", model_rd(32'h99AABBCC, 8, 23'd100)); #1;
        chk("st_refill_hit", {31'd0, hit_b}, 32'd1);
        sb_pop_chk({24'd0, rd_b});

        // Test 4: index conflict on a 32-bit ROM; ack and valid arrive in the same REQ cycle
        cyc(); cs_b = 1'b0; cs_c = 1'b1; rom_addr = 23'd2; #1;
        chk("t4_miss2", {31'd0, hit_c}, 32'd0);
        cyc(); ack = 1'b1; valid = 1'b1; cdata = 32'hA5A50002; #1;
        chk("t4_req2", {31'd0, req_c}, 32'd1);
        chk("t4_caddr2", {9'd0, caddr_c}, 32'h000002);
        cyc(); ack = 1'b0; valid = 1'b0; sb_push("t4_rd2", model_rd(32'hA5A50002, 32, 23'd2)); #1;
        chk("t4_hit2", {31'd0, hit_c}, 32'd1);
        sb_pop_chk(rd_c);
        chk("t4_idle", {31'd0, req_c}, 32'd0);
        cyc(); rom_addr = 23'd18; #1;
        chk("t4_miss18", {31'd0, hit_c}, 32'd0);
        cyc(); ack = 1'b1; valid = 1'b1; cdata = 32'h5A5A0012; #1;
        chk("t4_caddr18", {9'd0, caddr_c}, 32'h000012);
        cyc(); ack = 1'b0; valid = 1'b0; #1;
        chk("t4_hit18", {31'd0, hit_c}, 32'd1);
        cyc(); rom_addr = 23'd2; #1;
        chk("t4_evicted", {31'd0, hit_c}, 32'd0);
        cyc(); #1;
        chk("t4_rereq", {31'd0, req_c}, 32'd1);
        chk("t4_recaddr", {9'd0, caddr_c}, 32'h000002);
        cyc(); ack = 1'b1; valid = 1'b1; #1;
        cyc(); ack = 1'b0; valid = 1'b0; cs_c = 1'b0; #1;

        // Test 5: flush coincident with ctrl_valid in WAIT
        cyc(); cs_a = 1'b1; rom_addr = 23'd20; #1;
        chk("t5_miss", {31'd0, hit_a}, 32'd0);
        cyc(); ack = 1'b1; #1;
        chk("t5_req", {31'd0, req_a}, 32'd1);
        chk("t5_caddr", {9'd0, caddr_a}, 32'h01000A);
        cyc(); ack = 1'b0; valid = 1'b1; flush = 1'b1; cdata = 32'hCAFEF00D; #1;
        chk("t5_wait", {31'd0, req_a}, 32'd0);
        cyc(); valid = 1'b0; flush = 1'b0; #1;
        chk("t5_idle", {31'd0, req_a}, 32'd0);
        chk("t5_not_written", {31'd0, hit_a}, 32'd0);
`ifdef ROM_SEGMENT_STATS_EN
        chk("t5_hitcnt_clr", {16'd0, hc_a}, 32'd0);
        chk("t5_misscnt_clr", {16'd0, mc_a}, 32'd0);
`endif
        cyc(); #1;
        chk("t5_rereq", {31'd0, req_a}, 32'd1);
        chk("t5_recaddr", {9'd0, caddr_a}, 32'h01000A);

        // Test 6: reset in WAIT, then the orphaned ctrl_valid is ignored
        cyc(); ack = 1'b1; #1;
        cyc(); ack = 1'b0; #1;
        chk("t6_wait", {31'd0, req_a}, 32'd0);
        reset = 1'b1; #1;
        chk("t6_rst_req", {31'd0, req_a}, 32'd0);
        chk("t6_rst_caddr", {9'd0, caddr_a}, 32'd0);
        chk("t6_rst_rdata", {16'd0, rd_a}, 32'd0);
`ifdef ROM_SEGMENT_STATS_EN
        chk("t6_rst_hitcnt", {16'd0, hc_a}, 32'd0);
        chk("t6_rst_misscnt", {16'd0, mc_a}, 32'd0);
`endif
        cyc(); reset = 1'b0; cs_a = 1'b0; #1;
        cyc(); valid = 1'b1; cdata = 32'h12345678; #1;
        chk("t6_no_req", {31'd0, req_a}, 32'd0);
        cyc(); valid = 1'b0; cs_a = 1'b1; #1;
        chk("t6_valid_ignored", {31'd0, hit_a}, 32'd0);
        cyc(); #1;
        chk("t6_new_miss", {31'd0, req_a}, 32'd1);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
